// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if
//   Bundles the client command handshake and the VGA pixel-write port of
//   plot_scheduler so the drawing clients and the scheduler share one bus.
//
//   req_valid  [NUM_REQ]    per-client command valid
//   req_x/y/w/h[8*NUM_REQ]  rectangle origin and size, client i at [8i+7:8i]
//   req_colour [3*NUM_REQ]  fill colour, client i at [3i+2:3i]
//   req_ready  [NUM_REQ]    one-hot accept pulse
//   req_done   [NUM_REQ]    one-hot completion pulse
//   busy                    scheduler not idle
//   x_out, y_out, colour_out, plot   pixel write to vga_adapter
//
//   master: the drawing clients side; slave: the scheduler side.
interface plot_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [8*NUM_REQ-1:0] req_w;
    logic [8*NUM_REQ-1:0] req_h;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_done;
    logic                 busy;
    logic [7:0]           x_out;
    logic [7:0]           y_out;
    logic [2:0]           colour_out;
    logic                 plot;

    modport master (
        output req_valid, req_x, req_y, req_w, req_h, req_colour,
        input  req_ready, req_done, busy, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, req_colour,
        output req_ready, req_done, busy, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/plot_scheduler.sv
// plot_scheduler
//   Shares the single vga_adapter pixel port between NUM_REQ drawing clients.
//   Each client submits a filled rectangle; one client is granted round-robin,
//   its rectangle is rasterised one pixel per clock (x inner loop, y outer),
//   off-screen pixels are clipped (cycle still spent, plot low) and the client
//   receives a one-cycle done pulse.
//
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    plot_scheduler_if.slave: command handshake in, pixel port out
module plot_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    plot_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Coordinates are carried at 9 bits so x+w or y+h past 255 lands off-screen
    // instead of wrapping back onto it.
    localparam logic [8:0] LIM_X = 9'(SCREEN_W);
    localparam logic [8:0] LIM_Y = 9'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;         // client with highest priority next decision
    logic [IDX_W-1:0] owner;       // client whose command is in flight
    logic [8:0]       cur_x, cur_y;
    logic [8:0]       x_start, x_last, y_last;
    logic [2:0]       colour;
    logic             fin;         // every pixel of the command has been issued

    // Per-client fields unpacked so the winner can be selected by index.
    logic [7:0] fx [NUM_REQ];
    logic [7:0] fy [NUM_REQ];
    logic [7:0] fw [NUM_REQ];
    logic [7:0] fh [NUM_REQ];
    logic [2:0] fc [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign fx[i] = bus.req_x[8*i+7 -: 8];
        assign fy[i] = bus.req_y[8*i+7 -: 8];
        assign fw[i] = bus.req_w[8*i+7 -: 8];
        assign fh[i] = bus.req_h[8*i+7 -: 8];
        assign fc[i] = bus.req_colour[3*i+2 -: 3];
    end

    // Round-robin pick: first valid client at or after ptr, wrapping.
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a value before any branch, otherwise the
        // unassigned paths would infer latches.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // NOTE: the whole datapath, command latches included, is reset so that
    // no field carries stale contents into the first command after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            x_start        <= '0;
            x_last         <= '0;
            y_last         <= '0;
            colour         <= '0;
            fin            <= 1'b0;
            bus.req_ready  <= '0;
            bus.req_done   <= '0;
            bus.busy       <= 1'b0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
            bus.plot       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; the pulse defaults below are
            // overridden by later assignments in the same edge.
            bus.req_ready <= '0;
            bus.req_done  <= '0;
            bus.plot      <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner   <= grant_idx;
                        ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cur_x   <= {1'b0, fx[grant_idx]};
                        cur_y   <= {1'b0, fy[grant_idx]};
                        x_start <= {1'b0, fx[grant_idx]};
                        x_last  <= {1'b0, fx[grant_idx]} + {1'b0, fw[grant_idx]} - 9'd1;
                        y_last  <= {1'b0, fy[grant_idx]} + {1'b0, fh[grant_idx]} - 9'd1;
                        colour  <= fc[grant_idx];
                        // Zero-area commands skip straight to completion.
                        fin     <= (fw[grant_idx] == 8'd0) || (fh[grant_idx] == 8'd0);
                        bus.req_ready[grant_idx] <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= DRAW;
                    end
                end

                DRAW: begin
                    if (!fin) begin
                        bus.x_out      <= cur_x[7:0];
                        bus.y_out      <= cur_y[7:0];
                        bus.colour_out <= colour;
                        bus.plot       <= (cur_x < LIM_X) && (cur_y < LIM_Y);
                        if (cur_x == x_last) begin
                            cur_x <= x_start;
                            if (cur_y == y_last) begin
                                fin <= 1'b1;
                            end else begin
                                cur_y <= cur_y + 9'd1;
                            end
                        end else begin
                            cur_x <= cur_x + 9'd1;
                        end
                    end else begin
                        bus.req_done[owner] <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler
//   Self-checking bench for plot_scheduler. A behavioural model (round-robin
//   pointer plus a pixel list generated from the rectangle with integer
//   arithmetic) supplies every expected value; directed scenarios are followed
//   by randomized multi-client rounds.
module tb_plot_scheduler;
    localparam int N  = 3;
    localparam int SW = 160;
    localparam int SH = 120;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plot_scheduler_if #(.NUM_REQ(N)) bus ();

    plot_scheduler #(.NUM_REQ(N), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        int c;
        bit p;
    } pix_t;

    pix_t obs_q[$];
    pix_t exp_q[$];

    // Command fields each client currently presents.
    int cx[N], cy[N], cw[N], ch[N], cc[N];
    int model_ptr;

    // Results of the last observed transaction.
    int           g_idx;
    int           wait_cyc;
    bit           timed_out;
    bit           stray;
    logic [N-1:0] ready_vec, ready_c1, done_vec;
    logic         done_plot, done_busy;

    task automatic set_req(input int i, input int x, input int y, input int w,
                           input int h, input int c);
        cx[i] = x; cy[i] = y; cw[i] = w; ch[i] = h; cc[i] = c;
        bus.req_x[8*i +: 8]      = 8'(x);
        bus.req_y[8*i +: 8]      = 8'(y);
        bus.req_w[8*i +: 8]      = 8'(w);
        bus.req_h[8*i +: 8]      = 8'(h);
        bus.req_colour[3*i +: 3] = 3'(c);
        bus.req_valid[i]         = 1'b1;
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int i);
        model_ptr = (i + 1) % N;
    endfunction

    // Expected pixel stream: row by row, clipped where x or y leaves the screen.
    function automatic void build_exp(input int i);
        exp_q.delete();
        for (int yy = 0; yy < ch[i]; yy++) begin
            for (int xx = 0; xx < cw[i]; xx++) begin
                exp_q.push_back('{cx[i] + xx, cy[i] + yy, cc[i],
                                  (cx[i] + xx < SW) && (cy[i] + yy < SH)});
            end
        end
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0 && i < N) v[i] = 1'b1;
        return v;
    endfunction

    // Waits (bounded) for an accept, releases that client's valid, then records
    // every cycle up to and including the done pulse.
    task automatic observe();
        timed_out = 1'b0;
        stray     = 1'b0;
        g_idx     = -1;
        wait_cyc  = 0;
        obs_q.delete();
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (bus.req_ready == '0 && wait_cyc < 50);
        if (bus.req_ready == '0) begin
            timed_out = 1'b1;
            return;
        end
        ready_vec = bus.req_ready;
        for (int i = 0; i < N; i++) if (ready_vec[i] && g_idx < 0) g_idx = i;
        bus.req_valid[g_idx] = 1'b0;
        for (int t = 0; t < 70000; t++) begin
            @(negedge clk);
            if (t == 0) ready_c1 = bus.req_ready;
            else if (bus.req_ready != '0) stray = 1'b1;
            if (bus.req_done != '0) begin
                done_vec  = bus.req_done;
                done_plot = bus.plot;
                done_busy = bus.busy;
                return;
            end
            obs_q.push_back('{int'(bus.x_out), int'(bus.y_out), int'(bus.colour_out), bus.plot});
        end
        timed_out = 1'b1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_w      = '0;
        bus.req_h      = '0;
        bus.req_colour = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.req_ready !== '0 || bus.req_done !== '0 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b done=%b busy=%b plot=%b, required all 0",
                     bus.req_ready, bus.req_done, bus.busy, bus.plot);
        end
        vectors++;
        if (bus.x_out !== 8'd0 || bus.y_out !== 8'd0 || bus.colour_out !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_pixel: x=%0d y=%0d colour=%0d, required 0 0 0",
                     bus.x_out, bus.y_out, bus.colour_out);
        end
        reset     = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_ready !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 000", bus.busy, bus.req_ready);
        end
    endtask

    // Single-client commands from idle: normal fill, edge clipping, zero size,
    // and 9-bit overflow on x and on y.
    task automatic test_commands();
        int tbl[6][6] = '{
            '{0,  10,  20,  3,  2, 5},
            '{1, 158, 119,  4,  2, 2},
            '{2,  40,  40,  0,  5, 6},
            '{0, 250,  20, 10,  1, 3},
            '{1,   5, 250,  2, 10, 1},
            '{2, 159, 118,  1,  3, 4}
        };
        int eg;
        for (int n = 0; n < 6; n++) begin
            set_req(tbl[n][0], tbl[n][1], tbl[n][2], tbl[n][3], tbl[n][4], tbl[n][5]);
            eg = model_pick(bus.req_valid);
            build_exp(eg);
            observe();
            vectors++;
            if (timed_out) begin
                miscompares++;
                $display("FAIL cmd%0d_handshake: no ready/done within bound, required both", n);
                continue;
            end
            model_grant(eg);
            vectors++;
            if (ready_vec !== onehot(eg) || wait_cyc != 1 || ready_c1 !== '0) begin
                miscompares++;
                $display("FAIL cmd%0d_ready: ready=%b after %0d cycles, next=%b; required %b after 1, next 000",
                         n, ready_vec, wait_cyc, ready_c1, onehot(eg));
            end
            vectors++;
            if (obs_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL cmd%0d_length: %0d pixel cycles, required %0d", n, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                if (k < obs_q.size()) begin
                    vectors++;
                    if (obs_q[k].p !== exp_q[k].p || (exp_q[k].p &&
                        (obs_q[k].x != exp_q[k].x || obs_q[k].y != exp_q[k].y || obs_q[k].c != exp_q[k].c))) begin
                        miscompares++;
                        $display("FAIL cmd%0d_pixel%0d: plot=%0d (%0d,%0d) c=%0d, required plot=%0d (%0d,%0d) c=%0d",
                                 n, k + 1, obs_q[k].p, obs_q[k].x, obs_q[k].y, obs_q[k].c,
                                 exp_q[k].p, exp_q[k].x, exp_q[k].y, exp_q[k].c);
                    end
                end
            end
            vectors++;
            if (done_vec !== onehot(eg) || done_plot !== 1'b0 || done_busy !== 1'b1 || stray) begin
                miscompares++;
                $display("FAIL cmd%0d_done: done=%b plot=%b busy=%b stray_ready=%0d, required %b 0 1 0",
                         n, done_vec, done_plot, done_busy, stray, onehot(eg));
            end
            @(negedge clk);
            vectors++;
            if (bus.busy !== 1'b0 || bus.plot !== 1'b0 || bus.req_done !== '0) begin
                miscompares++;
                $display("FAIL cmd%0d_idle: busy=%b plot=%b done=%b, required 0 0 000",
                         n, bus.busy, bus.plot, bus.req_done);
            end
        end
    endtask

    // All clients request from reset, then 1 and 2 re-request.
    task automatic test_round_robin();
        int eg;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1 + i, 2 + i, 1, 1, i + 1);
        for (int n = 0; n < 5; n++) begin
            if (n == 3) begin
                set_req(1, 30, 31, 1, 1, 6);
                set_req(2, 40, 41, 1, 1, 7);
            end
            eg = model_pick(bus.req_valid);
            build_exp(eg);
            observe();
            vectors++;
            if (timed_out) begin
                miscompares++;
                $display("FAIL rr%0d_handshake: no ready/done within bound, required both", n);
                continue;
            end
            model_grant(eg);
            vectors++;
            if (ready_vec !== onehot(eg) || wait_cyc != ((n == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr%0d_grant: ready=%b after %0d cycles, required %b after %0d",
                         n, ready_vec, wait_cyc, onehot(eg), (n == 0) ? 1 : 2);
            end
            vectors++;
            if (obs_q.size() != 1 || obs_q[0].p !== 1'b1 || obs_q[0].x != exp_q[0].x ||
                obs_q[0].y != exp_q[0].y || obs_q[0].c != exp_q[0].c) begin
                miscompares++;
                $display("FAIL rr%0d_pixel: %0d cycles, first plot=%0d (%0d,%0d) c=%0d, required 1 cycle plot=1 (%0d,%0d) c=%0d",
                         n, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].p : 0,
                         (obs_q.size() > 0) ? obs_q[0].x : -1, (obs_q.size() > 0) ? obs_q[0].y : -1,
                         (obs_q.size() > 0) ? obs_q[0].c : -1, exp_q[0].x, exp_q[0].y, exp_q[0].c);
            end
            vectors++;
            if (done_vec !== onehot(eg) || stray) begin
                miscompares++;
                $display("FAIL rr%0d_done: done=%b stray_ready=%0d, required %b 0", n, done_vec, stray, onehot(eg));
            end
        end
        @(negedge clk);
    endtask

    // Reset during pixel 3 of a 4x4 fill, then a lone request from client 1.
    task automatic test_reset_mid();
        int cyc;
        set_req(0, 5, 5, 4, 4, 3);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.req_ready == '0 && cyc < 50);
        vectors++;
        if (bus.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_grant: ready=%b, required 001", bus.req_ready);
        end
        bus.req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.plot !== 1'b1 || bus.x_out !== 8'd7 || bus.y_out !== 8'd5) begin
            miscompares++;
            $display("FAIL mid_pixel3: plot=%b (%0d,%0d), required 1 (7,5)", bus.plot, bus.x_out, bus.y_out);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async: plot=%b busy=%b, required 0 0", bus.plot, bus.busy);
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (bus.req_done !== '0 || bus.plot !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_hold: done=%b plot=%b, required 000 0", bus.req_done, bus.plot);
            end
        end
        set_req(1, 60, 70, 2, 1, 2);
        reset     = 1'b0;
        model_ptr = 0;
        build_exp(1);
        observe();
        vectors++;
        if (timed_out || ready_vec !== 3'b010 || wait_cyc != 1 || obs_q.size() != 2 || done_vec !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_after: timeout=%0d ready=%b after %0d, %0d pixels, done=%b; required 0 010 after 1, 2, 010",
                     timed_out, ready_vec, wait_cyc, obs_q.size(), done_vec);
        end
        if (!timed_out) model_grant(1);
        @(negedge clk);
    endtask

    // Random subsets of clients with random rectangles, some crossing the edges.
    task automatic test_random();
        int eg, guard, first;
        logic [N-1:0] mask;
        for (int r = 0; r < 25; r++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) set_req(i, $urandom_range(0, 3) == 0 ? $urandom_range(150, 255) : $urandom_range(0, 150),
                                     $urandom_range(0, 3) == 0 ? $urandom_range(110, 255) : $urandom_range(0, 110),
                                     $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
            end
            guard = 0;
            first = 1;
            while (bus.req_valid != '0 && guard < 2 * N) begin
                guard++;
                eg = model_pick(bus.req_valid);
                build_exp(eg);
                observe();
                vectors++;
                if (timed_out) begin
                    miscompares++;
                    $display("FAIL rnd%0d_handshake: no ready/done within bound, required both", r);
                    bus.req_valid = '0;
                    break;
                end
                model_grant(eg);
                vectors++;
                if (ready_vec !== onehot(eg) || (!first && wait_cyc != 2)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_grant: ready=%b after %0d cycles, required %b", r, ready_vec, wait_cyc, onehot(eg));
                end
                first = 0;
                vectors++;
                if (obs_q.size() != exp_q.size() || done_vec !== onehot(eg) || done_plot !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd%0d_len: %0d cycles done=%b plot=%b, required %0d cycles done=%b plot=0",
                             r, obs_q.size(), done_vec, done_plot, exp_q.size(), onehot(eg));
                end
                foreach (exp_q[k]) begin
                    if (k < obs_q.size()) begin
                        vectors++;
                        if (obs_q[k].p !== exp_q[k].p || (exp_q[k].p &&
                            (obs_q[k].x != exp_q[k].x || obs_q[k].y != exp_q[k].y || obs_q[k].c != exp_q[k].c))) begin
                            miscompares++;
                            $display("FAIL rnd%0d_pixel%0d: plot=%0d (%0d,%0d) c=%0d, required plot=%0d (%0d,%0d) c=%0d",
                                     r, k + 1, obs_q[k].p, obs_q[k].x, obs_q[k].y, obs_q[k].c,
                                     exp_q[k].p, exp_q[k].x, exp_q[k].y, exp_q[k].c);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        model_ptr     = 0;
        test_reset();
        test_commands();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
